decode_stage: RTL and testbench

- Instruction decode stage that sits directly downstream of instruction memory.
- Consumes the 16-bit instruction word each cycle and owns the 16-entry register file.
- Issues decoded operands and control to the execute stage.
- Resolves bne/j and drives branch enable/target back to instruction fetch.
- Detects load-use hazards and stalls fetch.

---
 rtl/decode_stage.sv | 218 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage
// Instruction decode stage sitting directly downstream of instruction memory.
// Owns the 16-entry register file, decodes one 16-bit instruction per cycle
// into an execute-stage bundle, resolves bne/j and reports the redirect to
// fetch, and holds fetch for one cycle on a load-use hazard.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   instr_in            instruction word from fetch (op=[15:12] f1 f2 f3)
//   instr_valid         instr_in is valid this cycle
//   wb_en/addr/data     register file write port from writeback
//   stall               hold fetch PC (combinational)
//   be, branch_adr      registered branch enable / target to fetch
//   ex_*                registered execute-stage bundle
//   illegal             registered undefined-opcode flag
//
// Configuration:
//   DECODE_ILLEGAL_OP_EN  when defined, opcodes 8-15 raise illegal and issue
//                         as a bubble; otherwise they decode as nop and
//                         illegal is tied low.

module decode_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr_in,
  input  logic              instr_valid,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              be,
  output logic [ADDR_W-1:0] branch_adr,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              ex_reg_wr,
  output logic              illegal
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADDI = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_LW   = 4'd4,
    OP_SW   = 4'd5,
    OP_BNE  = 4'd6,
    OP_J    = 4'd7
  } opcode_e;

  logic [DATA_W-1:0] regs [NREGS];
  logic              squash;

  logic [3:0]        op;
  logic [ADDR_W-1:0] f1, f2, f3;
  logic [DATA_W-1:0] rd_f1, rd_f2, rd_f3;
  logic [DATA_W-1:0] imm_ext;
  logic              uses_f1, uses_f2, uses_f3;
  logic              load_use;
  logic              accept;
  logic              taken;
  logic              defined_op;

  logic              nxt_valid;
  logic [3:0]        nxt_op;
  logic [ADDR_W-1:0] nxt_rd;
  logic [DATA_W-1:0] nxt_a, nxt_b, nxt_imm;
  logic              nxt_mem_rd, nxt_mem_wr, nxt_reg_wr;
`ifdef DECODE_ILLEGAL_OP_EN
  logic              nxt_illegal;
`endif

  assign op      = instr_in[15:12];
  assign f1      = instr_in[11:8];
  assign f2      = instr_in[7:4];
  assign f3      = instr_in[3:0];
  assign imm_ext = {{(DATA_W-4){1'b0}}, instr_in[3:0]};

  // Read ports: r0 is hard zero, and a same-cycle writeback to the read
  // index is forwarded so decode never sees a stale value.
  assign rd_f1 = (f1 == '0) ? '0 : (wb_en && wb_addr == f1) ? wb_data : regs[f1];
  assign rd_f2 = (f2 == '0) ? '0 : (wb_en && wb_addr == f2) ? wb_data : regs[f2];
  assign rd_f3 = (f3 == '0) ? '0 : (wb_en && wb_addr == f3) ? wb_data : regs[f3];

  // Which instruction fields are register sources; used only for hazards.
  assign uses_f1 = (op == OP_SW) || (op == OP_BNE);
  assign uses_f2 = (op == OP_ADDI) || (op == OP_SUB) || (op == OP_AND) ||
                   (op == OP_LW)   || (op == OP_SW)  || (op == OP_BNE);
  assign uses_f3 = (op == OP_SUB) || (op == OP_AND);

  // A load in execute whose result the incoming instruction needs cannot be
  // forwarded in time, so fetch is held while a bubble goes down. The bubble
  // clears ex_valid, which ends the stall after exactly one cycle. An
  // instruction that is about to be squashed never needs to wait.
  assign load_use = ex_valid && ex_mem_rd && (ex_rd != '0) && instr_valid &&
                    ((uses_f1 && f1 == ex_rd) ||
                     (uses_f2 && f2 == ex_rd) ||
                     (uses_f3 && f3 == ex_rd));
  assign stall    = !rst && !squash && load_use;

  assign accept     = instr_valid && !stall && !squash;
  assign defined_op = (op != OP_NOP) && !op[3];
  assign taken      = accept && ((op == OP_J) || (op == OP_BNE && rd_f1 != rd_f2));

  // Build the next execute bundle; anything not accepted becomes a bubble
  // with every field cleared.
  always_comb begin
    nxt_valid  = 1'b0;
    nxt_op     = '0;
    nxt_rd     = '0;
    nxt_a      = '0;
    nxt_b      = '0;
    nxt_imm    = '0;
    nxt_mem_rd = 1'b0;
    nxt_mem_wr = 1'b0;
    nxt_reg_wr = 1'b0;
`ifdef DECODE_ILLEGAL_OP_EN
    nxt_illegal = 1'b0;
`endif
    if (accept) begin
      nxt_valid = 1'b1;
      if (defined_op) begin
        nxt_op  = op;
        nxt_rd  = f1;
        nxt_imm = imm_ext;
      end
      case (op)
        OP_NOP: ;
        OP_ADDI: begin
          nxt_a      = rd_f2;
          nxt_reg_wr = 1'b1;
        end
        OP_SUB, OP_AND: begin
          nxt_a      = rd_f2;
          nxt_b      = rd_f3;
          nxt_reg_wr = 1'b1;
        end
        OP_LW: begin
          nxt_a      = rd_f2;
          nxt_mem_rd = 1'b1;
          nxt_reg_wr = 1'b1;
        end
        OP_SW: begin
          nxt_a      = rd_f2;
          nxt_b      = rd_f1;
          nxt_mem_wr = 1'b1;
        end
        OP_BNE: begin
          nxt_a = rd_f2;
          nxt_b = rd_f1;
        end
        OP_J: ;
        default: begin
`ifdef DECODE_ILLEGAL_OP_EN
          nxt_valid   = 1'b0;
          nxt_illegal = 1'b1;
`else
          nxt_valid   = 1'b1;
`endif
        end
      endcase
    end
  end

  // Register file, squash flag, branch redirect and execute bundle. Reset
  // clears everything, which also drops any stalled or squashed instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      squash     <= 1'b0;
      be         <= 1'b0;
      branch_adr <= '0;
      ex_valid   <= 1'b0;
      ex_op      <= '0;
      ex_rd      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
      ex_reg_wr  <= 1'b0;
    end else begin
      if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
      squash     <= taken;
      be         <= taken;
      branch_adr <= taken ? f3 : '0;
      ex_valid   <= nxt_valid;
      ex_op      <= nxt_op;
      ex_rd      <= nxt_rd;
      ex_a       <= nxt_a;
      ex_b       <= nxt_b;
      ex_imm     <= nxt_imm;
      ex_mem_rd  <= nxt_mem_rd;
      ex_mem_wr  <= nxt_mem_wr;
      ex_reg_wr  <= nxt_reg_wr;
    end
  end

`ifdef DECODE_ILLEGAL_OP_EN
  // Undefined-opcode flag, aligned with the bubble issued in its place.
  always_ff @(posedge clk) begin
    if (rst) illegal <= 1'b0;
    else     illegal <= nxt_illegal;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage. A reference model of the register file and
// decode rules predicts each cycle's execute bundle, which is queued when the
// instruction is driven and compared when the DUT presents it.

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        stall;
  logic        be;
  logic [3:0]  branch_adr;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [3:0]  ex_rd;
  logic [15:0] ex_a;
  logic [15:0] ex_b;
  logic [15:0] ex_imm;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_reg_wr;
  logic        illegal;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .be(be), .branch_adr(branch_adr), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
    .illegal(illegal)
  );

  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic        mrd;
    logic        mwr;
    logic        rwr;
    logic        be;
    logic [3:0]  badr;
    logic        ill;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] model_regs [16];
  bit          model_squash;
  exp_t        prev_ex;
  bit          last_stall;
  int          checks   = 0;
  int          failures = 0;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [15:0] modelRead(input logic [3:0] idx, input logic we,
                                            input logic [3:0] wa, input logic [15:0] wd);
    if (idx == 4'd0) return 16'h0;
    if (we && wa == idx) return wd;
    return model_regs[idx];
  endfunction

  function automatic bit readsReg(input logic [15:0] ins, input logic [3:0] r);
    case (ins[15:12])
      4'd1, 4'd4: return ins[7:4] == r;
      4'd2, 4'd3: return (ins[7:4] == r) || (ins[3:0] == r);
      4'd5, 4'd6: return (ins[11:8] == r) || (ins[7:4] == r);
      default:    return 1'b0;
    endcase
  endfunction

  // Expected bundle for an accepted instruction.
  function automatic exp_t modelIssue(input logic [15:0] ins, input logic we,
                                      input logic [3:0] wa, input logic [15:0] wd);
    exp_t e;
    logic [15:0] s1, s2, s3;
    s1 = modelRead(ins[11:8], we, wa, wd);
    s2 = modelRead(ins[7:4], we, wa, wd);
    s3 = modelRead(ins[3:0], we, wa, wd);
    e = '0;
    e.v = 1'b1;
    if (ins[15:12] >= 4'd1 && ins[15:12] <= 4'd7) begin
      e.op  = ins[15:12];
      e.rd  = ins[11:8];
      e.imm = {12'h0, ins[3:0]};
    end
    case (ins[15:12])
      4'd0: ;
      4'd1: begin e.a = s2; e.rwr = 1'b1; end
      4'd2, 4'd3: begin e.a = s2; e.b = s3; e.rwr = 1'b1; end
      4'd4: begin e.a = s2; e.mrd = 1'b1; e.rwr = 1'b1; end
      4'd5: begin e.a = s2; e.b = s1; e.mwr = 1'b1; end
      4'd6: begin
        e.a = s2;
        e.b = s1;
        if (s1 != s2) begin e.be = 1'b1; e.badr = ins[3:0]; end
      end
      4'd7: begin e.be = 1'b1; e.badr = ins[3:0]; end
      default: begin
`ifdef DECODE_ILLEGAL_OP_EN
        e = '0;
        e.ill = 1'b1;
`else
        e = '0;
        e.v = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic checkBundle();
    exp_t e;
    if (expq.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL queue: got empty expected one entry at %0t", $time);
      return;
    end
    e = expq.pop_front();
    checkOutput("ex_valid",   {15'h0, ex_valid},   {15'h0, e.v});
    checkOutput("ex_op",      {12'h0, ex_op},      {12'h0, e.op});
    checkOutput("ex_rd",      {12'h0, ex_rd},      {12'h0, e.rd});
    checkOutput("ex_a",       ex_a,                e.a);
    checkOutput("ex_b",       ex_b,                e.b);
    checkOutput("ex_imm",     ex_imm,              e.imm);
    checkOutput("ex_mem_rd",  {15'h0, ex_mem_rd},  {15'h0, e.mrd});
    checkOutput("ex_mem_wr",  {15'h0, ex_mem_wr},  {15'h0, e.mwr});
    checkOutput("ex_reg_wr",  {15'h0, ex_reg_wr},  {15'h0, e.rwr});
    checkOutput("be",         {15'h0, be},         {15'h0, e.be});
    checkOutput("branch_adr", {12'h0, branch_adr}, {12'h0, e.badr});
    checkOutput("illegal",    {15'h0, illegal},    {15'h0, e.ill});
  endtask

  // Drive one cycle of inputs at the falling edge, check stall, queue the
  // predicted bundle, advance the model, then check at the next falling edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] ins,
                               input logic we = 1'b0, input logic [3:0] wa = 4'h0,
                               input logic [15:0] wd = 16'h0);
    exp_t e;
    bit   exp_stall;
    bit   accept;
    rst = r; instr_valid = v; instr_in = ins;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    exp_stall = !r && !model_squash && v && prev_ex.v && prev_ex.mrd &&
                (prev_ex.rd != 4'd0) && readsReg(ins, prev_ex.rd);
    checkOutput("stall", {15'h0, stall}, {15'h0, exp_stall});
    last_stall = exp_stall;
    accept = !r && v && !exp_stall && !model_squash;
    e = '0;
    if (accept) e = modelIssue(ins, we, wa, wd);
    expq.push_back(e);
    if (r) begin
      for (int i = 0; i < 16; i++) model_regs[i] = 16'h0;
      model_squash = 1'b0;
      prev_ex = '0;
    end else begin
      if (we && wa != 4'd0) model_regs[wa] = wd;
      model_squash = e.be;
      prev_ex = e;
    end
    @(negedge clk);
    checkBundle();
  endtask

  initial begin
    logic [15:0] ins;
    logic        v, we;
    logic [3:0]  wa;
    logic [15:0] wd;
    rst = 1'b1; instr_valid = 1'b0; instr_in = 16'h0;
    wb_en = 1'b0; wb_addr = 4'h0; wb_data = 16'h0;
    prev_ex = '0; model_squash = 1'b0; last_stall = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 16'h0;
    @(negedge clk);

    // Reset with a valid word present: everything must read zero.
    applyStimulus(1'b1, 1'b1, 16'h1105);
    applyStimulus(1'b1, 1'b1, 16'h1105);

    // addi r1,r0,5 then writeback R1=5, sub with R2 bypass, write to r0.
    applyStimulus(1'b0, 1'b1, 16'h1105);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 4'd1, 16'h0005);
    applyStimulus(1'b0, 1'b1, 16'h2412, 1'b1, 4'd2, 16'h0007);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 4'd0, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 16'h3500);
    applyStimulus(1'b0, 1'b0, 16'h1105);

    // Load-use: one stall and one bubble, then sub issues.
    applyStimulus(1'b0, 1'b1, 16'h4130);
    applyStimulus(1'b0, 1'b1, 16'h2412);
    applyStimulus(1'b0, 1'b1, 16'h2412);

    // Load to r0 never stalls; sw reads f1 as a hazard source.
    applyStimulus(1'b0, 1'b1, 16'h4030);
    applyStimulus(1'b0, 1'b1, 16'h2200);
    applyStimulus(1'b0, 1'b1, 16'h4230);
    applyStimulus(1'b0, 1'b1, 16'h5210);
    applyStimulus(1'b0, 1'b1, 16'h5210);

    // Taken bne squashes the following lw.
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 4'd4, 16'h0003);
    applyStimulus(1'b0, 1'b1, 16'h614C);
    applyStimulus(1'b0, 1'b1, 16'h4130);
    applyStimulus(1'b0, 1'b1, 16'h0000);

    // Not-taken bne: lw issues normally.
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 4'd4, 16'h0005);
    applyStimulus(1'b0, 1'b1, 16'h614C);
    applyStimulus(1'b0, 1'b1, 16'h4130);

    // bne whose operand is being loaded resolves only after the stall.
    applyStimulus(1'b0, 1'b1, 16'h614C);
    applyStimulus(1'b0, 1'b1, 16'h614C);

    // j squashes the next word; then an undefined opcode.
    applyStimulus(1'b0, 1'b1, 16'h700C);
    applyStimulus(1'b0, 1'b1, 16'h1105);
    applyStimulus(1'b0, 1'b1, 16'h9000);
    applyStimulus(1'b0, 1'b1, 16'hF123);

    // Reset arriving mid-branch and mid-stall.
    applyStimulus(1'b0, 1'b1, 16'h7003);
    applyStimulus(1'b1, 1'b1, 16'h1105);
    applyStimulus(1'b0, 1'b1, 16'h4130);
    applyStimulus(1'b0, 1'b1, 16'h2412);
    applyStimulus(1'b1, 1'b1, 16'h2412);
    applyStimulus(1'b0, 1'b1, 16'h2412);

    // Random traffic on a few registers to provoke hazards and branches.
    ins = 16'h0;
    for (int k = 0; k < 80; k++) begin
      if (!last_stall) begin
        ins = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        v = ($urandom_range(0, 9) != 0);
      end else begin
        v = 1'b1;
      end
      we = $urandom_range(0, 1) == 1;
      wa = 4'($urandom_range(0, 3));
      wd = 16'($urandom_range(0, 3));
      applyStimulus(1'b0, v, ins, we, wa, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
